// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: IF state encoding, IF/ID bus width, reset PC.
// Imported by every stage of the five-stage core.
package riscv_pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IF_ID_BUS_W  = 64;
    localparam logic [31:0] NOP_INST     = 32'h0000_0033;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_stage_pc_gen.sv
// PC register for the fetch stage: reset value, sequential +4 and
// word-aligned redirect target.
module if_pc_gen
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_jmp_flag,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              adv,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_nxt;

    always_comb begin
        pc_nxt = pc;
        if (br_jmp_flag) begin
            pc_nxt = br_target & ~ADDR_W'(3);
        end else if (adv) begin
            pc_nxt = pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry
// buffer toward decode, redirect with wrong-path discard.
module if_fetch_stage
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   br_jmp_flag,
    input  logic [ADDR_W-1:0]      br_target,
    input  logic                   ds_allowin,
    output logic                   fs_to_ds_valid,
    output logic [IF_ID_BUS_W-1:0] if_id_bus_out,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata
);

    if_state_e              state, state_nxt;
    logic                   discard, discard_nxt;
    logic [IF_ID_BUS_W-1:0] buffer, buffer_nxt;
    logic                   adv;
    logic [ADDR_W-1:0]      pc;

    if_pc_gen #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_jmp_flag (br_jmp_flag),
        .br_target   (br_target),
        .adv         (adv),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            discard <= 1'b0;
            buffer  <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            buffer  <= buffer_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        discard_nxt    = discard;
        buffer_nxt     = buffer;
        imem_req       = 1'b0;
        fs_to_ds_valid = 1'b0;
        adv            = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = rst_n;
                if (imem_ready) begin
                    state_nxt   = WAIT;
                    discard_nxt = br_jmp_flag;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    discard_nxt = 1'b0;
                    if (br_jmp_flag || discard) begin
                        state_nxt = FETCH;
                    end else begin
                        buffer_nxt = {imem_rdata, pc};
                        state_nxt  = HOLD;
                    end
                end else if (br_jmp_flag) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                fs_to_ds_valid = !br_jmp_flag;
                if (br_jmp_flag) begin
                    state_nxt = FETCH;
                end else if (ds_allowin) begin
                    adv       = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign imem_addr     = pc;
    assign if_id_bus_out = buffer;

endmodule
